// File: rtl/bw_io_misc_bscan_seq.sv
// Boundary-scan sequencer for the misc pad ring: one CAPTURE-SHIFT-UPDATE pass per
// command, with clock_dr/update_dr strobes synthesized from rclk by a phase counter.
module bw_io_misc_bscan_seq #(
    parameter int CHAIN_W = 32,
    parameter int CNT_W   = 6,
    parameter int CKDIV   = 2
) (
    input  logic               rclk,
    input  logic               arst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_len,
    input  logic [CHAIN_W-1:0] cmd_data,
    input  logic               cmd_extest,
    input  logic               cmd_hiz,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [CHAIN_W-1:0] rsp_data,
    output logic               busy,
    output logic               bscan_hiz_l_out,
    output logic               bscan_mode_ctl_out,
    output logic               bscan_shift_dr_out,
    output logic               bscan_clock_dr_out,
    output logic               bscan_update_dr_out,
    output logic               bsi,
    input  logic               bso
);
    localparam int PH_W = (2 * CKDIV > 2) ? $clog2(2 * CKDIV) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * CKDIV - 1);
    localparam logic [PH_W-1:0]  PH_HI   = PH_W'(CKDIV);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(CHAIN_W);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CAPTURE = 3'd1;
    localparam logic [2:0] SHIFT   = 3'd2;
    localparam logic [2:0] UPDATE  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [CNT_W-1:0]   idx_q, idx_d, len_q, len_d, idx_inc;
    logic [CHAIN_W-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
    logic               mode_q, mode_d, hiz_l_q, hiz_l_d;
    logic               shift_q, shift_d, clock_q, clock_d, update_q, update_d;
    logic               bsi_q, bsi_d, rsp_valid_q, rsp_valid_d;
    logic               cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic               slot_end, hi_d;

    assign slot_end = (ph_q == PH_LAST);
    assign idx_inc  = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        idx_d      = idx_q;
        len_d      = len_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        mode_d     = mode_q;
        hiz_l_d    = hiz_l_q;
        if (state_q != IDLE && state_q != DONE)
            ph_d = slot_end ? '0 : ph_q + 1'b1;
        case (state_q)
            IDLE: if (cmd_valid) begin
                len_d      = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                data_d     = cmd_data;
                mode_d     = cmd_extest;
                hiz_l_d    = ~cmd_hiz;
                rsp_data_d = '0;
                idx_d      = '0;
                ph_d       = '0;
                state_d    = CAPTURE;
            end
            CAPTURE: if (slot_end) state_d = (len_q == '0) ? UPDATE : SHIFT;
            SHIFT: if (slot_end) begin
                // bso is taken just before the next clock_dr rise; data_q[0] is always the bit on bsi
                for (int i = 0; i < CHAIN_W; i++)
                    if (idx_q == CNT_W'(i)) rsp_data_d[i] = bso;
                data_d = data_q >> 1;
                idx_d  = idx_inc;
                if (idx_inc == len_q) state_d = UPDATE;
            end
            UPDATE: if (slot_end) state_d = DONE;
            DONE:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        hi_d        = (ph_d < PH_HI);
        shift_d     = (state_d == SHIFT);
        clock_d     = (state_d == CAPTURE || state_d == SHIFT) && hi_d;
        update_d    = (state_d == UPDATE) && hi_d;
        bsi_d       = (state_d == SHIFT) ? data_d[0] : 1'b0;
        rsp_valid_d = (state_d == DONE);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            mode_q      <= 1'b0;
            hiz_l_q     <= 1'b1;
            shift_q     <= 1'b0;
            clock_q     <= 1'b0;
            update_q    <= 1'b0;
            bsi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            mode_q      <= mode_d;
            hiz_l_q     <= hiz_l_d;
            shift_q     <= shift_d;
            clock_q     <= clock_d;
            update_q    <= update_d;
            bsi_q       <= bsi_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready           = cmd_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_data            = rsp_data_q;
    assign busy                = busy_q;
    assign bscan_hiz_l_out     = hiz_l_q;
    assign bscan_mode_ctl_out  = mode_q;
    assign bscan_shift_dr_out  = shift_q;
    assign bscan_clock_dr_out  = clock_q;
    assign bscan_update_dr_out = update_q;
    assign bsi                 = bsi_q;
endmodule

// File: tb/tb_bw_io_misc_bscan_seq.sv
// Bench for bw_io_misc_bscan_seq: pad-ring chain model on bsi/bso, response scoreboard,
// and a CKDIV=1 instance for strobe-width checks.
module tb_bw_io_misc_bscan_seq;
    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic        arst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_extest = 1'b0, cmd_hiz = 1'b0, rsp_ready = 1'b0;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, busy, hiz_l, mode_ctl, shift_dr, clock_dr, update_dr, bsi;
    logic [31:0] rsp_data;
    logic        bso_m = 1'b0;

    logic        d1_cmd_valid = 1'b0, d1_rsp_ready = 1'b0, d1_bso = 1'b1;
    logic [5:0]  d1_cmd_len = '0;
    logic [31:0] d1_cmd_data = '0;
    logic        d1_cmd_ready, d1_rsp_valid, d1_busy, d1_hiz_l, d1_mode_ctl;
    logic        d1_shift_dr, d1_clock_dr, d1_update_dr, d1_bsi;
    logic [31:0] d1_rsp_data;

    bw_io_misc_bscan_seq #(.CHAIN_W(32), .CNT_W(6), .CKDIV(2)) u_dut (
        .rclk(rclk), .arst(arst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_extest(cmd_extest), .cmd_hiz(cmd_hiz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
        .bscan_hiz_l_out(hiz_l), .bscan_mode_ctl_out(mode_ctl), .bscan_shift_dr_out(shift_dr),
        .bscan_clock_dr_out(clock_dr), .bscan_update_dr_out(update_dr), .bsi(bsi), .bso(bso_m));

    bw_io_misc_bscan_seq #(.CHAIN_W(32), .CNT_W(6), .CKDIV(1)) u_dut1 (
        .rclk(rclk), .arst(arst), .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready),
        .cmd_len(d1_cmd_len), .cmd_data(d1_cmd_data), .cmd_extest(1'b0), .cmd_hiz(1'b0),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_data(d1_rsp_data), .busy(d1_busy),
        .bscan_hiz_l_out(d1_hiz_l), .bscan_mode_ctl_out(d1_mode_ctl), .bscan_shift_dr_out(d1_shift_dr),
        .bscan_clock_dr_out(d1_clock_dr), .bscan_update_dr_out(d1_update_dr), .bsi(d1_bsi), .bso(d1_bso));

    int cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    // Pad-ring chain model: a clock_dr rise with shift_dr high shifts bsi in at the far end,
    // and the cell leaving the chain is held in the bso output flop.
    logic [31:0] chain = '0, pre_val = '0;
    int          chain_len = 8;
    bit          pre_req = 1'b0, pre_seen = 1'b0;
    logic        clk_prev = 1'b0, upd_prev = 1'b0;
    int          cap_cnt = 0, shf_cnt = 0, upd_cnt = 0, inv_viol = 0;

    function automatic logic [31:0] shift_in(input logic [31:0] c, input logic b, input int n);
        logic [31:0] r;
        r = c >> 1;
        r[n-1] = b;
        return r;
    endfunction

    always @(negedge rclk) begin
        clk_prev <= clock_dr;
        upd_prev <= update_dr;
        if (pre_req != pre_seen) begin
            chain    <= pre_val;
            pre_seen <= pre_req;
        end else if (clock_dr && !clk_prev && shift_dr) begin
            bso_m <= chain[0];
            chain <= shift_in(chain, bsi, chain_len);
        end
        if (clock_dr && !clk_prev) begin
            if (shift_dr) shf_cnt <= shf_cnt + 1;
            else          cap_cnt <= cap_cnt + 1;
        end
        if (update_dr && !upd_prev) upd_cnt <= upd_cnt + 1;
        if ((shift_dr && update_dr) || (clock_dr && update_dr)) inv_viol <= inv_viol + 1;
    end

    typedef struct { logic [31:0] data; int lat; } exp_t;
    exp_t sb[$];
    int   checks = 0, errors = 0, e0 = 0;

    task automatic tick;
        @(posedge rclk); #1;
    endtask

    task automatic preload(input int n, input logic [31:0] v);
        chain_len = n;
        pre_val   = v;
        pre_req   = ~pre_req;
        tick;
    endtask

    task automatic start_cmd(input int len, input logic [31:0] data, input logic ext,
                             input logic hz, input logic [31:0] exp_data);
        exp_t e;
        int   le;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL start_ready: cmd_ready=%b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_len = 6'(len); cmd_data = data; cmd_extest = ext; cmd_hiz = hz;
        tick;
        cmd_valid = 1'b0;
        e0 = cyc;
        le = (len > 32) ? 32 : len;
        e.data = exp_data;
        e.lat  = (le > 0) ? 4 * (le + 2) : 8;
        sb.push_back(e);
    endtask

    task automatic wait_rsp(output logic [31:0] d, output int lat, output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick;
            if (rsp_valid === 1'b1) begin to = 1'b0; break; end
        end
        d   = rsp_data;
        lat = cyc - e0;
    endtask

    task automatic handshake;
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({cmd_ready, rsp_valid, busy, hiz_l, mode_ctl, shift_dr, clock_dr, update_dr, bsi} !== 9'b100_100_000
            || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_vals: rdy/val/busy/hizl/mode/sh/ck/up/bsi=%b rsp=%h want 100100000 0",
                     {cmd_ready, rsp_valid, busy, hiz_l, mode_ctl, shift_dr, clock_dr, update_dr, bsi}, rsp_data);
        end
    endtask

    task automatic test_reset_mid_shift;
        int u0;
        preload(8, 32'h3C);
        start_cmd(8, 32'hA5, 1'b1, 1'b1, 32'h3C);
        while (cyc < e0 + 13) tick;
        checks++;
        if (shift_dr !== 1'b1) begin errors++; $display("FAIL pre_abort_shift: shift_dr=%b want 1", shift_dr); end
        u0 = upd_cnt;
        arst = 1'b1;
        #1;
        test_reset;
        sb.delete();
        tick; tick;
        arst = 1'b0;
        tick; tick;
        checks++;
        if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL abort_update: pulses=%0d want 0", upd_cnt - u0); end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle: busy=%b cmd_ready=%b want 0 1", busy, cmd_ready);
        end
    endtask

    task automatic test_basic_pass;
        exp_t e; logic [31:0] d; int lat; bit to; int c0, s0, u0;
        preload(8, 32'h3C);
        c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
        start_cmd(8, 32'hA5, 1'b0, 1'b0, 32'h3C);
        wait_rsp(d, lat, to);
        e = sb.pop_front();
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: no rsp_valid"); end
        checks++;
        if (d !== e.data) begin errors++; $display("FAIL basic_data: got %h want %h", d, e.data); end
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, e.lat); end
        checks++;
        if (chain[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_chain: got %h want a5", chain[7:0]); end
        checks++;
        if (cap_cnt - c0 !== 1 || shf_cnt - s0 !== 8 || upd_cnt - u0 !== 1) begin
            errors++; $display("FAIL basic_pulses: cap/shf/upd=%0d/%0d/%0d want 1/8/1",
                               cap_cnt - c0, shf_cnt - s0, upd_cnt - u0);
        end
        handshake;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL basic_release: rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_len_zero;
        exp_t e; logic [31:0] d; int lat; bit to; int c0, s0, u0;
        c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
        start_cmd(0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        wait_rsp(d, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || d !== e.data || lat !== e.lat) begin
            errors++; $display("FAIL len0_rsp: timeout=%b data=%h lat=%0d want 0 %h %0d", to, d, lat, e.data, e.lat);
        end
        checks++;
        if (cap_cnt - c0 !== 1 || shf_cnt - s0 !== 0 || upd_cnt - u0 !== 1) begin
            errors++; $display("FAIL len0_pulses: cap/shf/upd=%0d/%0d/%0d want 1/0/1",
                               cap_cnt - c0, shf_cnt - s0, upd_cnt - u0);
        end
        checks++;
        if (chain[7:0] !== 8'hA5) begin errors++; $display("FAIL len0_chain: got %h want a5", chain[7:0]); end
        handshake;
    endtask

    task automatic test_len_clamp;
        exp_t e; logic [31:0] d, pv, dv; int lat; bit to; int s0;
        pv = $urandom; dv = $urandom;
        preload(32, pv);
        s0 = shf_cnt;
        start_cmd(63, dv, 1'b0, 1'b0, pv);
        wait_rsp(d, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || d !== e.data || lat !== e.lat) begin
            errors++; $display("FAIL clamp_rsp: timeout=%b data=%h lat=%0d want 0 %h %0d", to, d, lat, e.data, e.lat);
        end
        checks++;
        if (shf_cnt - s0 !== 32) begin errors++; $display("FAIL clamp_pulses: got %0d want 32", shf_cnt - s0); end
        checks++;
        if (chain !== dv) begin errors++; $display("FAIL clamp_chain: got %h want %h", chain, dv); end
        handshake;
    endtask

    task automatic test_rsp_hold;
        exp_t e; logic [31:0] d; int lat; bit to; int s0;
        preload(8, 32'h5A);
        start_cmd(4, 32'h3, 1'b0, 1'b0, 32'hA);
        wait_rsp(d, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || d !== e.data || lat !== e.lat) begin
            errors++; $display("FAIL hold_rsp: timeout=%b data=%h lat=%0d want 0 %h %0d", to, d, lat, e.data, e.lat);
        end
        s0 = shf_cnt;
        cmd_valid = 1'b1; cmd_len = 6'd8; cmd_data = 32'hFF;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL hold_cycle%0d: valid=%b data=%h ready=%b busy=%b want 1 %h 0 1",
                                   i, rsp_valid, rsp_data, cmd_ready, busy, e.data);
            end
        end
        cmd_valid = 1'b0;
        handshake;
        tick; tick;
        checks++;
        if (busy !== 1'b0 || shf_cnt !== s0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL hold_ignored: busy=%b shifts=%0d valid=%b want 0 0 0", busy, shf_cnt - s0, rsp_valid);
        end
    endtask

    task automatic test_back_to_back_mode;
        exp_t e; logic [31:0] d; int lat; bit to;
        preload(8, 32'h0);
        start_cmd(2, 32'h0, 1'b1, 1'b1, 32'h0);
        checks++;
        if (mode_ctl !== 1'b1 || hiz_l !== 1'b0) begin
            errors++; $display("FAIL mode_apply: mode=%b hiz_l=%b want 1 0", mode_ctl, hiz_l);
        end
        wait_rsp(d, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || d !== e.data || lat !== e.lat) begin
            errors++; $display("FAIL mode_rsp: timeout=%b data=%h lat=%0d want 0 %h %0d", to, d, lat, e.data, e.lat);
        end
        handshake;
        tick; tick; tick;
        checks++;
        if (mode_ctl !== 1'b1 || hiz_l !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mode_held: mode=%b hiz_l=%b busy=%b want 1 0 0", mode_ctl, hiz_l, busy);
        end
        preload(8, 32'h1);
        start_cmd(1, 32'h1, 1'b0, 1'b0, 32'h1);
        checks++;
        if (mode_ctl !== 1'b0 || hiz_l !== 1'b1) begin
            errors++; $display("FAIL mode_clear: mode=%b hiz_l=%b want 0 1", mode_ctl, hiz_l);
        end
        wait_rsp(d, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || d !== e.data || lat !== e.lat) begin
            errors++; $display("FAIL b2b_rsp: timeout=%b data=%h lat=%0d want 0 %h %0d", to, d, lat, e.data, e.lat);
        end
        handshake;
    endtask

    task automatic test_ckdiv1;
        logic ck_e, up_e, sh_e;
        int   slot;
        checks++;
        if (d1_cmd_ready !== 1'b1) begin errors++; $display("FAIL d1_ready: got %b want 1", d1_cmd_ready); end
        d1_cmd_valid = 1'b1; d1_cmd_len = 6'd3;
        tick;
        d1_cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            slot = k / 2;
            ck_e = (slot <= 3) && (k % 2 == 0);
            up_e = (slot == 4) && (k % 2 == 0);
            sh_e = (slot >= 1) && (slot <= 3);
            checks++;
            if (d1_clock_dr !== ck_e || d1_update_dr !== up_e || d1_shift_dr !== sh_e || d1_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL d1_cycle%0d: ck/up/sh/val=%b%b%b%b want %b%b%b0",
                                   k, d1_clock_dr, d1_update_dr, d1_shift_dr, d1_rsp_valid, ck_e, up_e, sh_e);
            end
            tick;
        end
        checks++;
        if (d1_rsp_valid !== 1'b1 || d1_rsp_data !== 32'h7) begin
            errors++; $display("FAIL d1_rsp: valid=%b data=%h want 1 00000007", d1_rsp_valid, d1_rsp_data);
        end
        d1_rsp_ready = 1'b1; tick; d1_rsp_ready = 1'b0;
    endtask

    initial begin
        tick; tick;
        test_reset;
        arst = 1'b0;
        tick;
        test_reset_mid_shift;
        test_basic_pass;
        test_len_zero;
        test_len_clamp;
        test_rsp_hold;
        test_back_to_back_mode;
        test_ckdiv1;
        checks++;
        if (inv_viol !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", inv_viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
